// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map constants and shared types
// for the board interrupt controller.
package irq_ctrl_pkg;

  localparam logic [1:0] REG_IE   = 2'd0;
  localparam logic [1:0] REG_IP   = 2'd1;
  localparam logic [1:0] REG_TYPE = 2'd2;
  localparam logic [1:0] REG_POL  = 2'd3;

  localparam int BANK_STRIDE = 4;
  localparam int MAX_INTS    = 16;

  typedef enum logic {
    ARMING = 1'b0,
    RUN    = 1'b1
  } arm_state_e;

  function automatic int num_banks(input int n);
    return (n + 7) / 8;
  endfunction

endpackage

// File: rtl/irq_ctrl_chan.sv
// irq_ctrl_chan: one interrupt channel with synchroniser,
// event detect and a set-over-clear pending bit.
module irq_ctrl_chan #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic int_i,
  input  logic edge_i,
  input  logic pol_i,
  input  logic en_i,
  input  logic clr_i,
  output logic ip_o
);

  logic s;
  logic p_q;
  logic ev;
  logic ip_q;
  logic ip_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = int_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw source through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= int_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Edges compare raw s/p; level matches s to POL each cycle
  always_comb begin
    ev = 1'b0;
    unique case (1'b1)
      edge_i && pol_i:  ev = s & ~p_q;
      edge_i && !pol_i: ev = ~s & p_q;
      default:          ev = (s == pol_i);
    endcase
    ip_d = (en_i & ev) | (ip_q & ~clr_i);
  end

  // Delayed copy of s and the pending bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q  <= 1'b0;
      ip_q <= 1'b0;
    end else begin
      p_q  <= s;
      ip_q <= ip_d;
    end
  end

  assign ip_o = ip_q;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: up to 16 edge/level interrupt sources, W1C
// pending bits and a registered maskable irq on the CSR bus.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [4:0]          BASE_ADDR   = 5'h1c,
  parameter int                  NUM_INTS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_INTS-1:0] DFL_IE      = '0,
  parameter logic [NUM_INTS-1:0] DFL_TYPE    = '1,
  parameter logic [NUM_INTS-1:0] DFL_POL     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_INTS-1:0] int_i,
  output logic                irq
);

  localparam int NB  = num_banks(NUM_INTS);
  localparam int BSH = $clog2(BANK_STRIDE);
  localparam int BW  = 5 - BSH;
  localparam logic [BW-1:0] NBV = BW'(NB);
  localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

  logic [4:0]          off;
  logic [BW-1:0]       bank;
  logic [BSH-1:0]      rsel;
  logic                hit;
  logic [NUM_INTS-1:0] ie_q, ie_d;
  logic [NUM_INTS-1:0] ty_q, ty_d;
  logic [NUM_INTS-1:0] po_q, po_d;
  logic [NUM_INTS-1:0] clr;
  logic [NUM_INTS-1:0] ip;
  arm_state_e          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                run;
  logic                irq_q;

  assign off  = csr_a - BASE_ADDR;
  assign bank = off[4:BSH];
  assign rsel = off[BSH-1:0];
  assign hit  = (bank < NBV);

  // CSR writes: config updates and W1C strobes per channel
  always_comb begin
    ie_d = ie_q;
    ty_d = ty_q;
    po_d = po_q;
    clr  = '0;
    for (int i = 0; i < NUM_INTS; i++) begin
      if (csr_we && hit && bank == BW'(i / 8)) begin
        unique case (rsel)
          REG_IE:   ie_d[i] = csr_di[i % 8];
          REG_IP:   clr[i]  = csr_di[i % 8];
          REG_TYPE: ty_d[i] = csr_di[i % 8];
          REG_POL:  po_d[i] = csr_di[i % 8];
        endcase
      end
    end
  end

  // Read mux; unowned addresses and unused bits read 0
  always_comb begin
    csr_do = '0;
    for (int i = 0; i < NUM_INTS; i++) begin
      if (hit && bank == BW'(i / 8)) begin
        unique case (rsel)
          REG_IE:   csr_do[i % 8] = ie_q[i];
          REG_IP:   csr_do[i % 8] = ip[i];
          REG_TYPE: csr_do[i % 8] = ty_q[i];
          REG_POL:  csr_do[i % 8] = po_q[i];
        endcase
      end
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q <= DFL_IE;
      ty_q <= DFL_TYPE;
      po_q <= DFL_POL;
    end else begin
      ie_q <= ie_d;
      ty_q <= ty_d;
      po_q <= po_d;
    end
  end

  // Arming state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARMING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold events off until the synchroniser has filled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARMING: begin
        if (cnt_q == ARM_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RUN: ;
    endcase
  end

  assign run = (state_q == RUN);

  for (genvar g = 0; g < NUM_INTS; g++) begin : g_chan
    irq_ctrl_chan #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .int_i (int_i[g]),
      .edge_i(ty_q[g]),
      .pol_i (po_q[g]),
      .en_i  (run),
      .clr_i (clr[g]),
      .ip_o  (ip[g])
    );
  end

  // Registered request from enabled pending bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(ip & ie_q);
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and random stimulus against a
// sample-history model of the interrupt controller.
module tb_irq_ctrl;

  localparam int N = 12;
  localparam int S = 2;
  localparam logic [4:0] BASE = 5'h1c;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   csr_a;
  logic [7:0]   csr_di;
  logic         csr_we;
  logic [7:0]   csr_do;
  logic [N-1:0] int_i;
  logic         irq;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] m_ie, m_ty, m_po, m_ip;
  logic         m_irq;
  logic [N-1:0] samp[$];
  logic [7:0]   seen_do;
  logic         seen_irq;

  logic [4:0] al [9] = '{5'h1c, 5'h1d, 5'h1e, 5'h1f,
                         5'h00, 5'h01, 5'h02, 5'h03, 5'h04};

  irq_ctrl #(
    .BASE_ADDR  (BASE),
    .NUM_INTS   (N),
    .SYNC_STAGES(S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .csr_a (csr_a),
    .csr_di(csr_di),
    .csr_we(csr_we),
    .csr_do(csr_do),
    .int_i (int_i),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ie  = '0;
    m_ty  = '1;
    m_po  = '0;
    m_ip  = '0;
    m_irq = 1'b0;
    samp.delete();
  endtask

  // input value sampled at edge j after reset release
  function automatic logic [N-1:0] smp(input int j);
    if (j >= 1) return samp[j-1];
    return '0;
  endfunction

  // events seen at edge t: s is the input S edges ago
  function automatic logic [N-1:0] events(input int t);
    logic [N-1:0] s, p, e;
    s = smp(t - S);
    p = smp(t - S - 1);
    e = '0;
    if (t < S + 3) return '0;
    for (int c = 0; c < N; c++) begin
      if (m_ty[c]) e[c] = m_po[c] ? (s[c] && !p[c]) : (!s[c] && p[c]);
      else         e[c] = (s[c] == m_po[c]);
    end
    return e;
  endfunction

  function automatic logic [7:0] mread(input logic [4:0] a);
    logic [4:0]  off;
    logic [15:0] v;
    int b;
    off = a - BASE;
    b = int'(off[4:2]);
    if (b >= 2) return 8'h00;
    case (off[1:0])
      2'd0:    v = 16'(m_ie);
      2'd1:    v = 16'(m_ip);
      2'd2:    v = 16'(m_ty);
      default: v = 16'(m_po);
    endcase
    v = v >> (8 * b);
    return v[7:0];
  endfunction

  task automatic cyc(input logic [N-1:0] iv, input logic [4:0] a,
                     input logic [7:0] d, input logic we);
    logic [4:0]   off;
    logic [15:0]  wm16, wb16;
    logic [N-1:0] wm, wb, ev, nie, nty, npo, nip;
    logic         nirq;
    int b, t;
    @(negedge clk);
    int_i  = iv;
    csr_a  = a;
    csr_di = d;
    csr_we = we;
    #1;
    seen_do  = csr_do;
    seen_irq = irq;
    chk("rd", csr_do, mread(a));
    chk("irq", {7'b0, irq}, {7'b0, m_irq});
    t = samp.size() + 1;
    samp.push_back(iv);
    ev = events(t);
    off = a - BASE;
    b = int'(off[4:2]);
    wm16 = '0;
    wb16 = '0;
    if (we && b < 2) begin
      wm16 = 16'hff << (8 * b);
      wb16 = 16'(d) << (8 * b);
    end
    wm = wm16[N-1:0];
    wb = wb16[N-1:0] & wm;
    nie = m_ie;
    nty = m_ty;
    npo = m_po;
    nip = m_ip;
    case (off[1:0])
      2'd0:    nie = (m_ie & ~wm) | wb;
      2'd1:    nip = m_ip & ~wb;
      2'd2:    nty = (m_ty & ~wm) | wb;
      default: npo = (m_po & ~wm) | wb;
    endcase
    nip  = nip | ev;
    nirq = |(m_ip & m_ie);
    @(posedge clk);
    m_ie  = nie;
    m_ty  = nty;
    m_po  = npo;
    m_ip  = nip;
    m_irq = nirq;
  endtask

  task automatic idle(input int n, input logic [N-1:0] iv,
                      input logic [4:0] a);
    repeat (n) cyc(iv, a, 8'h00, 1'b0);
  endtask

  initial begin
    logic [N-1:0] cur;
    rst_n  = 1'b0;
    int_i  = '1;
    csr_a  = 5'h1d;
    csr_di = '0;
    csr_we = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    cyc(12'hfff, 5'h1d, 8'h00, 1'b0);
    chk("rst_ip", seen_do, 8'h00);
    chk("rst_irq", {7'b0, seen_irq}, 8'h00);
    cyc(12'hfff, 5'h1c, 8'h00, 1'b0);
    chk("rst_ie", seen_do, 8'h00);
    cyc(12'hfff, 5'h02, 8'h00, 1'b0);
    chk("rst_type1", seen_do, 8'h0f);
    idle(6, 12'hfff, 5'h1d);

    cyc(12'hfff, 5'h1c, 8'h01, 1'b1);
    cyc(12'hffe, 5'h1d, 8'h00, 1'b0);
    cyc(12'hffe, 5'h1d, 8'h00, 1'b0);
    cyc(12'hfff, 5'h1d, 8'h00, 1'b0);
    chk("ch0_ip_k1", seen_do, 8'h00);
    cyc(12'hfff, 5'h1d, 8'h00, 1'b0);
    chk("ch0_ip_k2", seen_do, 8'h01);
    chk("ch0_irq_k2", {7'b0, seen_irq}, 8'h00);
    cyc(12'hfff, 5'h1d, 8'h00, 1'b0);
    chk("ch0_irq_k3", {7'b0, seen_irq}, 8'h01);
    cyc(12'hfff, 5'h1d, 8'h01, 1'b1);
    cyc(12'hfff, 5'h1d, 8'h00, 1'b0);
    chk("ch0_w1c_ip", seen_do, 8'h00);
    chk("ch0_irq_w", {7'b0, seen_irq}, 8'h01);
    cyc(12'hfff, 5'h1d, 8'h00, 1'b0);
    chk("ch0_irq_drop", {7'b0, seen_irq}, 8'h00);

    cyc(12'hfff, 5'h1e, 8'hf7, 1'b1);
    cyc(12'hfff, 5'h1f, 8'h08, 1'b1);
    idle(2, 12'hfff, 5'h1d);
    chk("lvl_set", seen_do, 8'h08);
    cyc(12'hfff, 5'h1d, 8'h08, 1'b1);
    cyc(12'hfff, 5'h1d, 8'h00, 1'b0);
    chk("lvl_reset", seen_do, 8'h08);
    idle(4, 12'hff7, 5'h1d);
    cyc(12'hff7, 5'h1d, 8'h08, 1'b1);
    idle(2, 12'hff7, 5'h1d);
    chk("lvl_clr", seen_do, 8'h00);

    cyc(12'hff7, 5'h1c, 8'h00, 1'b1);
    cyc(12'hfd7, 5'h1d, 8'h00, 1'b0);
    cyc(12'hfd7, 5'h1d, 8'h00, 1'b0);
    idle(4, 12'hff7, 5'h1d);
    chk("ch5_ip", seen_do, 8'h20);
    chk("ch5_irq_off", {7'b0, seen_irq}, 8'h00);
    cyc(12'hff7, 5'h1c, 8'h20, 1'b1);
    cyc(12'hff7, 5'h1d, 8'h00, 1'b0);
    chk("ch5_irq_w", {7'b0, seen_irq}, 8'h00);
    cyc(12'hff7, 5'h1d, 8'h00, 1'b0);
    chk("ch5_irq_up", {7'b0, seen_irq}, 8'h01);

    cyc(12'hff7, 5'h1f, 8'h0c, 1'b1);
    idle(4, 12'hff3, 5'h1d);
    cyc(12'hff7, 5'h1d, 8'h00, 1'b0);
    cyc(12'hff7, 5'h1d, 8'h00, 1'b0);
    cyc(12'hff7, 5'h1d, 8'h04, 1'b1);
    cyc(12'hff7, 5'h1d, 8'h00, 1'b0);
    chk("set_wins", seen_do, 8'h24);

    cyc(12'hff7, 5'h00, 8'hff, 1'b1);
    cyc(12'hff7, 5'h00, 8'h00, 1'b0);
    chk("b1_ie", seen_do, 8'h0f);
    cyc(12'h7f7, 5'h01, 8'h00, 1'b0);
    cyc(12'h7f7, 5'h01, 8'h00, 1'b0);
    idle(4, 12'hff7, 5'h01);
    chk("b1_ip", seen_do, 8'h08);
    cyc(12'hff7, 5'h04, 8'h00, 1'b0);
    chk("no_decode", seen_do, 8'h00);

    #2;
    csr_we = 1'b0;
    csr_a  = 5'h1d;
    rst_n  = 1'b0;
    #1;
    chk("arst_ip", csr_do, 8'h00);
    chk("arst_irq", {7'b0, irq}, 8'h00);
    csr_a = 5'h01;
    #1;
    chk("arst_ip1", csr_do, 8'h00);
    m_reset();
    int_i = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(8, 12'h000, 5'h1d);
    chk("hold_ip0", seen_do, 8'h00);
    cyc(12'h000, 5'h01, 8'h00, 1'b0);
    chk("hold_ip1", seen_do, 8'h00);
    idle(4, 12'hfff, 5'h1d);
    chk("rise_noev", seen_do, 8'h00);

    cur = 12'hfff;
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) cur[c] = ~cur[c];
      end
      a = al[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) a = 5'($urandom);
      cyc(cur, a, 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
